// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: merges the inst and data channels onto one shared sram-like port, one transaction in flight.
// Define ARB_RR_EN for round-robin tie breaking; otherwise data has fixed priority over inst.
module sram_like_arbiter #(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } grant_t;

  state_t state_q, state_d;
  grant_t grant_q, grant_d;
  logic   pick_data;

`ifdef ARB_RR_EN
  // 1 = data channel won the most recent grant
  logic rr_last_data_q, rr_last_data_d;
`endif

  // State, grant and round-robin history registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= GNT_NONE;
`ifdef ARB_RR_EN
      rr_last_data_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
`ifdef ARB_RR_EN
      rr_last_data_q <= rr_last_data_d;
`endif
    end
  end

  // Next-state, arbitration and channel steering
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    pick_data    = 1'b0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
`ifdef ARB_RR_EN
    rr_last_data_d = rr_last_data_q;
    // On a tie the channel that did not win last time takes the grant
    pick_data      = data_req && (!inst_req || !rr_last_data_q);
`else
    pick_data      = data_req;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (inst_req || data_req) begin
          state_d = ST_REQ;
          grant_d = pick_data ? GNT_DATA : GNT_INST;
`ifdef ARB_RR_EN
          rr_last_data_d = pick_data;
`endif
        end
      end

      ST_REQ: begin
        mem_req = 1'b1;
        if (grant_q == GNT_DATA) begin
          mem_wr    = data_wr;
          mem_wstrb = data_wstrb;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
        end else begin
          mem_addr  = inst_addr;
        end
        if (mem_addr_ok) begin
          state_d      = ST_RESP;
          inst_addr_ok = (grant_q == GNT_INST);
          data_addr_ok = (grant_q == GNT_DATA);
        end
      end

      ST_RESP: begin
        if (mem_data_ok) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          if (grant_q == GNT_DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter; tie-break expectations follow ARB_RR_EN.
module tb_sram_like_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A master must keep its request up while the shared port is presenting it
  always @(posedge clk) begin
    if (!reset && mem_req)
      assert (inst_req || data_req) else $error("request dropped while mem_req is high");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout exp completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  // Ends on a falling edge with reset just released and the DUT in IDLE
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    inst_req = 1'b1;
    data_req = 1'b1;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_hold_mem_req: got %b exp 0", mem_req); end
    do_reset(); #1;
    checks++; if ({mem_req, mem_wr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 000000", {mem_req, mem_wr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb: got %h exp 0", mem_wstrb); end
    checks++; if ({mem_addr, mem_wdata, inst_rdata, data_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_buses: got %h exp 0", {mem_addr, mem_wdata, inst_rdata, data_rdata}); end
  endtask

  task automatic test_inst_read();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL inst_decide_cycle_mem_req: got %b exp 0", mem_req); end
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    checks++; if ({mem_req, mem_wr, inst_addr_ok, data_addr_ok} !== 4'b1010) begin
      errors++; $display("FAIL inst_req_ctrl: got %b exp 1010", {mem_req, mem_wr, inst_addr_ok, data_addr_ok}); end
    checks++; if (mem_addr !== 32'h1C00_0000) begin errors++; $display("FAIL inst_mem_addr: got %h exp 1c000000", mem_addr); end
    @(negedge clk); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0000; #1;
    checks++; if ({mem_req, inst_addr_ok, inst_data_ok, data_data_ok} !== 4'b0010) begin
      errors++; $display("FAIL inst_resp_ctrl: got %b exp 0010", {mem_req, inst_addr_ok, inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'h0280_0000) begin errors++; $display("FAIL inst_rdata: got %h exp 02800000", inst_rdata); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL inst_other_rdata: got %h exp 0", data_rdata); end
    @(negedge clk); mem_data_ok = 1'b0; mem_rdata = '0; #1;
    checks++; if ({mem_req, inst_data_ok} !== 2'b00) begin errors++; $display("FAIL inst_after_ctrl: got %b exp 00", {mem_req, inst_data_ok}); end
  endtask

  task automatic test_priority();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    checks++; if ({mem_req, mem_wr, data_addr_ok, inst_addr_ok} !== 4'b1110) begin
      errors++; $display("FAIL prio_data_ctrl: got %b exp 1110", {mem_req, mem_wr, data_addr_ok, inst_addr_ok}); end
    checks++; if ({mem_wstrb, mem_addr, mem_wdata} !== {4'hF, 32'h100, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL prio_data_bus: got %h exp f00000100deadbeef", {mem_wstrb, mem_addr, mem_wdata}); end
    @(negedge clk); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678; #1;
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin errors++; $display("FAIL prio_data_ack: got %b exp 10", {data_data_ok, inst_data_ok}); end
    checks++; if (data_rdata !== 32'h1234_5678) begin errors++; $display("FAIL prio_data_rdata: got %h exp 12345678", data_rdata); end
    @(negedge clk); mem_data_ok = 1'b0; mem_rdata = '0; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL prio_gap_mem_req: got %b exp 0", mem_req); end
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    checks++; if ({mem_req, mem_wr, inst_addr_ok, data_addr_ok} !== 4'b1010) begin
      errors++; $display("FAIL prio_inst_ctrl: got %b exp 1010", {mem_req, mem_wr, inst_addr_ok, data_addr_ok}); end
    checks++; if ({mem_wstrb, mem_addr, mem_wdata} !== {4'h0, 32'h1C00_0004, 32'h0}) begin
      errors++; $display("FAIL prio_inst_bus: got %h exp 01c00000400000000", {mem_wstrb, mem_addr, mem_wdata}); end
    @(negedge clk); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_00AA; #1;
    checks++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'hAA}) begin
      errors++; $display("FAIL prio_inst_resp: got %h exp 2000000aa", {inst_data_ok, data_data_ok, inst_rdata}); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_data;
`ifdef ARB_RR_EN
    exp_data = 4'b0101;
`else
    exp_data = 4'b1111;
`endif
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1000;
    data_req = 1'b1; data_addr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_addr_ok = 1'b1; #1;
      checks++; if ({data_addr_ok, inst_addr_ok} !== (exp_data[i] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL b2b_grant[%0d]: got %b exp %b", i, {data_addr_ok, inst_addr_ok}, exp_data[i] ? 2'b10 : 2'b01); end
      checks++; if (mem_addr !== (exp_data[i] ? 32'h2000 : 32'h1000)) begin
        errors++; $display("FAIL b2b_addr[%0d]: got %h exp %h", i, mem_addr, exp_data[i] ? 32'h2000 : 32'h1000); end
      @(negedge clk); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h100 + 32'(i); #1;
      checks++; if ({data_data_ok, inst_data_ok} !== (exp_data[i] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL b2b_resp[%0d]: got %b exp %b", i, {data_data_ok, inst_data_ok}, exp_data[i] ? 2'b10 : 2'b01); end
      @(negedge clk); mem_data_ok = 1'b0; mem_rdata = '0;
    end
    clear_inputs();
  endtask

  task automatic test_addr_stall();
    do_reset();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if ({mem_req, mem_wr, data_addr_ok, inst_addr_ok, mem_addr} !== {4'b1000, 32'h200}) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h exp 800000200", i, {mem_req, mem_wr, data_addr_ok, inst_addr_ok, mem_addr}); end
    end
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    checks++; if ({mem_req, data_addr_ok} !== 2'b11) begin errors++; $display("FAIL stall_accept: got %b exp 11", {mem_req, data_addr_ok}); end
    @(negedge clk); data_req = 1'b0; mem_addr_ok = 1'b0; #1;
    checks++; if ({mem_req, data_addr_ok, data_data_ok} !== 3'b000) begin
      errors++; $display("FAIL stall_resp_wait: got %b exp 000", {mem_req, data_addr_ok, data_data_ok}); end
    @(negedge clk); mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
    checks++; if ({data_data_ok, data_rdata} !== {1'b1, 32'h5555_AAAA}) begin
      errors++; $display("FAIL stall_resp: got %h exp 15555aaaa", {data_data_ok, data_rdata}); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_stray_data_ok();
    do_reset();
    mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_0001; #1;
    checks++; if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== 66'h0) begin
      errors++; $display("FAIL stray_idle: got %h exp 0", {inst_data_ok, data_data_ok, inst_rdata, data_rdata}); end
    @(negedge clk); mem_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h300;
    @(negedge clk); mem_data_ok = 1'b1; #1;
    checks++; if ({mem_req, inst_data_ok, data_data_ok} !== 3'b100) begin
      errors++; $display("FAIL stray_req_wait: got %b exp 100", {mem_req, inst_data_ok, data_data_ok}); end
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    checks++; if ({data_addr_ok, inst_data_ok, data_data_ok} !== 3'b100) begin
      errors++; $display("FAIL stray_req_accept: got %b exp 100", {data_addr_ok, inst_data_ok, data_data_ok}); end
    @(negedge clk); data_req = 1'b0; mem_addr_ok = 1'b0; mem_rdata = 32'h77; #1;
    checks++; if ({data_data_ok, data_rdata, inst_rdata} !== {1'b1, 32'h77, 32'h0}) begin
      errors++; $display("FAIL stray_real_resp: got %h exp 10000007700000000", {data_data_ok, data_rdata, inst_rdata}); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h40;
    @(negedge clk); mem_addr_ok = 1'b1;
    @(negedge clk); inst_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); mem_data_ok = 1'b1; mem_rdata = 32'hCAFE; #1;
    checks++; if ({inst_data_ok, data_data_ok, inst_rdata} !== 34'h0) begin
      errors++; $display("FAIL rst_resp_stray: got %h exp 0", {inst_data_ok, data_data_ok, inst_rdata}); end
    @(negedge clk); mem_data_ok = 1'b0; mem_rdata = '0; data_req = 1'b1; data_addr = 32'h44; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_resp_idle: got %b exp 0", mem_req); end
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    checks++; if ({mem_req, data_addr_ok, mem_addr} !== {2'b11, 32'h44}) begin
      errors++; $display("FAIL rst_resp_new_req: got %h exp 300000044", {mem_req, data_addr_ok, mem_addr}); end
    @(negedge clk); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h99; #1;
    checks++; if ({data_data_ok, data_rdata} !== {1'b1, 32'h99}) begin
      errors++; $display("FAIL rst_resp_new_resp: got %h exp 100000099", {data_data_ok, data_rdata}); end
    @(negedge clk); clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_inst_read();
    test_priority();
    test_back_to_back();
    test_addr_stall();
    test_stray_data_ok();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
